imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the 8-bit microprocessor core: the memory end of the fetch interface the core drives with `pc`. It holds a 256-entry × 8-bit program store and loads it through a byte-stream handshake. It then answers core fetches with a registered instruction one cycle later. While no valid program is present it holds the core stalled.

## Interface

Parameters:
- `ADDR_W`, 8: fetch/write address width; store depth is 2^ADDR_W.
- `DATA_W`, 8: instruction width, with op[7:6], rs[5:4], rt[3:2] and rd[1:0].

Ports:
- `origclk` (in, 1): sole clock; all state updates on its rising edge.
- `reset` (in, 1): synchronous, active-low reset, sampled on the rising edge of `origclk`.
- `load_start` (in, 1): one-cycle pulse that begins or restarts a program load.
- `load_valid` (in, 1): `load_data` is valid.
- `load_data` (in, DATA_W): program byte.
- `load_last` (in, 1): qualifies the final byte of the program.
- `load_ready` (out, 1): responder accepts a byte this cycle.
- `fetch_req` (in, 1): core requests the instruction at `pc`.
- `pc` (in, ADDR_W): fetch address.
- `instruction` (out, DATA_W): registered fetch result.
- `instr_valid` (out, 1): `instruction` is the result of the request issued on the previous cycle.
- `cpu_hold` (out, 1): core must stall; high whenever the state is not RUN.
- `prog_len` (out, ADDR_W+1): number of bytes in the loaded program, 0..256.
- `fault` (out, 1): sticky out-of-range fetch flag.

## Operation

- State register: EMPTY, LOAD, RUN. Encoding is free.
- **EMPTY** (reset state): `load_start` → LOAD. All other inputs are ignored.
- **LOAD:**
  - On entry, the write pointer and `prog_len` clear to 0 and `fault` clears.
  - `load_ready` = 1.
  - A beat is `load_valid & load_ready`. Each beat writes `load_data` to mem[wptr], then increments `wptr` and `prog_len`.
  - A beat with `load_last` = 1 → RUN.
  - The 256th beat → RUN regardless of `load_last`; the pointer never wraps.
  - `load_start` in LOAD restarts the load (pointer and length to 0). A beat in that same cycle is dropped.
- **RUN:**
  - `load_ready` = 0.
  - `fetch_req` sampled high → on the next edge, `instruction` = mem[pc] and `instr_valid` = 1. Back-to-back requests give one result per cycle.
  - `load_start` → LOAD. A `fetch_req` in the same cycle is dropped, and `instr_valid` is 0 on the next cycle.
- In EMPTY and LOAD, `fetch_req` is ignored: `instr_valid` = 0 and `instruction` holds its last value.
- `cpu_hold` = (state != RUN), decoded from the state register only.
- Memory array is not reset; its contents are undefined until loaded.

## Timing

- Reset values: state EMPTY, `load_ready` 0, `instruction` 8'h00, `instr_valid` 0, `cpu_hold` 1, `prog_len` 0, `fault` 0, write pointer 0.
- Reset asserted mid-load or mid-run: all of the above on the next edge. Partial program is discarded (`prog_len` 0).
- Fetch latency is exactly 1 cycle, with no bubbles in RUN.
- Load throughput is 1 byte per cycle.
- LOAD→RUN occurs on the edge that accepts the last beat. `cpu_hold` falls in the following cycle, and a fetch may be issued then.
- A byte written in cycle N is readable by a fetch issued in cycle N+1 or later.
- `load_start` in EMPTY or RUN: `load_ready` = 1 from the next cycle.

## Configuration

- `IMEM_BOUNDS_CHECK_EN` defined:
  - A RUN fetch with `pc` ≥ `prog_len` returns 8'h00 with `instr_valid` = 1.
  - `fault` sets on that edge and stays set until reset or the next `load_start`.
- Not defined:
  - Fetches return mem[pc] raw, including undefined or stale locations.
  - `fault` is tied 0, and no compare logic is built.

## Test plan

- Reset, then check `cpu_hold`=1, `load_ready`=0, and `instr_valid`=0 while `fetch_req` toggles. Pulse `load_start`, stream 0x41, 0x82, 0xC3 (last on 0xC3) → `prog_len`=3, `cpu_hold` falls one cycle after the last beat.
- RUN, `fetch_req` on pc 0, 1, 2 in consecutive cycles → `instruction` 0x41, 0x82, 0xC3 on the three following cycles, `instr_valid` high continuously.
- Load 256 bytes (value = index) with no `load_last` → RUN after beat 256, `prog_len`=256. Fetch pc 255 → 0xFF.
- With `IMEM_BOUNDS_CHECK_EN`, 3-byte program, fetch pc 5 → `instruction` 0x00, `instr_valid` 1, `fault` 1. `fault` stays 1 until `load_start`, then clears.
- RUN, `load_start` and `fetch_req` in the same cycle → next cycle `instr_valid`=0, `cpu_hold`=1, `load_ready`=1, `prog_len`=0.
- Mid-load (2 of 5 bytes), `reset` low one cycle → EMPTY, `prog_len`=0, `load_ready`=0. A `load_valid` beat that follows is ignored.

Source files
------------

// File: rtl/imem_responder.sv
// 256x8 instruction store: byte-stream load (1 byte/cycle, load_ready high only in LOAD), 1-cycle registered fetch in RUN.
// Core is held (cpu_hold) outside RUN; define IMEM_BOUNDS_CHECK_EN for out-of-range fetch zeroing and a sticky fault flag.
module imem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              origclk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   prog_len,
    output logic              fault
);

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                vld_q, vld_d;
    logic                fault_q, fault_d;
    logic                wr_en;
    logic                oob;
    logic [ADDR_W-1:0]   wptr;
    logic [DATA_W-1:0]   mem_q [2**ADDR_W];

    // The program length doubles as the write pointer; it never reaches 2^ADDR_W while in LOAD.
    assign wptr = len_q[ADDR_W-1:0];

`ifdef IMEM_BOUNDS_CHECK_EN
    assign oob = ({1'b0, pc} >= len_q);
`else
    assign oob = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        fault_d = fault_q;
        wr_en   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    len_d   = '0;
                    fault_d = 1'b0;
                end
            end
            S_LOAD: begin
                // A restart wins over a beat presented in the same cycle.
                if (load_start) begin
                    len_d   = '0;
                    fault_d = 1'b0;
                end else if (load_valid) begin
                    wr_en = 1'b1;
                    len_d = len_q + LEN_ONE;
                    if (load_last || (&wptr)) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    len_d   = '0;
                    fault_d = 1'b0;
                end else if (fetch_req) begin
                    vld_d = 1'b1;
                    if (oob) begin
                        instr_d = '0;
                        fault_d = 1'b1;
                    end else begin
                        instr_d = mem_q[pc];
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge origclk) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            len_q   <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge origclk) begin
        if (wr_en && reset) begin
            mem_q[wptr] <= load_data;
        end
    end

    assign load_ready  = (state_q == S_LOAD);
    assign cpu_hold    = (state_q != S_RUN);
    assign instruction = instr_q;
    assign instr_valid = vld_q;
    assign prog_len    = len_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: vector table plus full-depth load and bounds sequences.
module tb_imem_responder;

    logic       origclk = 1'b0;
    logic       reset;
    logic       load_start, load_valid, load_last, fetch_req;
    logic [7:0] load_data, pc;
    logic       load_ready, instr_valid, cpu_hold, fault;
    logic [7:0] instruction;
    logic [8:0] prog_len;

    int checks = 0;
    int errors = 0;

    always #5 origclk = ~origclk;

    imem_responder #(.ADDR_W(8), .DATA_W(8)) dut (
        .origclk    (origclk),
        .reset      (reset),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .cpu_hold   (cpu_hold),
        .prog_len   (prog_len),
        .fault      (fault)
    );

    typedef struct {
        logic       rst_n, ls, lv;
        logic [7:0] ld;
        logic       ll, fr;
        logic [7:0] pc;
        logic [7:0] e_instr;
        logic       e_vld, e_hold, e_rdy;
        logic [8:0] e_len;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t v(input logic rst_n, ls, lv, input logic [7:0] ld, input logic ll, fr,
                               input logic [7:0] p, input logic [7:0] ei, input logic ev, eh, er,
                               input logic [8:0] el);
        vec_t r;
        r.rst_n = rst_n; r.ls = ls; r.lv = lv; r.ld = ld; r.ll = ll; r.fr = fr; r.pc = p;
        r.e_instr = ei; r.e_vld = ev; r.e_hold = eh; r.e_rdy = er; r.e_len = el;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, ls, lv, input logic [7:0] ld, input logic ll, fr,
                         input logic [7:0] p);
        reset = rst_n; load_start = ls; load_valid = lv; load_data = ld;
        load_last = ll; fetch_req = fr; pc = p;
    endtask

    task automatic tick();
        @(posedge origclk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        //            rst ls lv data  ll fr pc      instr  vld hold rdy len
        tbl[0]  = v(0, 0, 0, 8'h00, 0, 1, 8'h00,  8'h00, 0, 1, 0, 9'd0);
        tbl[1]  = v(1, 0, 0, 8'h00, 0, 1, 8'h00,  8'h00, 0, 1, 0, 9'd0);
        tbl[2]  = v(1, 0, 0, 8'h00, 0, 0, 8'h00,  8'h00, 0, 1, 0, 9'd0);
        tbl[3]  = v(1, 1, 0, 8'h00, 0, 0, 8'h00,  8'h00, 0, 1, 1, 9'd0);
        tbl[4]  = v(1, 0, 1, 8'h41, 0, 0, 8'h00,  8'h00, 0, 1, 1, 9'd1);
        tbl[5]  = v(1, 0, 1, 8'h82, 0, 0, 8'h00,  8'h00, 0, 1, 1, 9'd2);
        tbl[6]  = v(1, 0, 1, 8'hC3, 1, 0, 8'h00,  8'h00, 0, 0, 0, 9'd3);
        tbl[7]  = v(1, 0, 0, 8'h00, 0, 1, 8'h00,  8'h41, 1, 0, 0, 9'd3);
        tbl[8]  = v(1, 0, 0, 8'h00, 0, 1, 8'h01,  8'h82, 1, 0, 0, 9'd3);
        tbl[9]  = v(1, 0, 0, 8'h00, 0, 1, 8'h02,  8'hC3, 1, 0, 0, 9'd3);
        tbl[10] = v(1, 0, 0, 8'h00, 0, 0, 8'h00,  8'hC3, 0, 0, 0, 9'd3);
        tbl[11] = v(1, 1, 0, 8'h00, 0, 1, 8'h00,  8'hC3, 0, 1, 1, 9'd0);
        tbl[12] = v(1, 0, 1, 8'h11, 0, 0, 8'h00,  8'hC3, 0, 1, 1, 9'd1);
        tbl[13] = v(1, 0, 1, 8'h22, 0, 0, 8'h00,  8'hC3, 0, 1, 1, 9'd2);
        tbl[14] = v(0, 0, 1, 8'h33, 0, 0, 8'h00,  8'h00, 0, 1, 0, 9'd0);
        tbl[15] = v(1, 0, 1, 8'h44, 1, 0, 8'h00,  8'h00, 0, 1, 0, 9'd0);
        tbl[16] = v(1, 1, 1, 8'h55, 0, 0, 8'h00,  8'h00, 0, 1, 1, 9'd0);
        tbl[17] = v(1, 0, 1, 8'h66, 0, 0, 8'h00,  8'h00, 0, 1, 1, 9'd1);
        tbl[18] = v(1, 1, 1, 8'h77, 0, 0, 8'h00,  8'h00, 0, 1, 1, 9'd0);
        tbl[19] = v(1, 0, 1, 8'h88, 1, 0, 8'h00,  8'h00, 0, 0, 0, 9'd1);
        tbl[20] = v(1, 0, 0, 8'h00, 0, 1, 8'h00,  8'h88, 1, 0, 0, 9'd1);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst_n, tbl[i].ls, tbl[i].lv, tbl[i].ld, tbl[i].ll, tbl[i].fr, tbl[i].pc);
            tick();
            chk($sformatf("row%0d instruction", i), instruction, tbl[i].e_instr);
            chk($sformatf("row%0d instr_valid", i), instr_valid, tbl[i].e_vld);
            chk($sformatf("row%0d cpu_hold", i), cpu_hold, tbl[i].e_hold);
            chk($sformatf("row%0d load_ready", i), load_ready, tbl[i].e_rdy);
            chk($sformatf("row%0d prog_len", i), prog_len, tbl[i].e_len);
            chk($sformatf("row%0d fault", i), fault, 1'b0);
        end

        // Full-depth load with no load_last: must enter RUN on the 256th beat.
        drive(1, 1, 0, 8'h00, 0, 0, 8'h00);
        tick();
        chk("full load_ready", load_ready, 1'b1);
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 1, 8'(i), 0, 0, 8'h00);
            tick();
            if (i == 254) begin
                chk("full len255", prog_len, 9'd255);
                chk("full hold255", cpu_hold, 1'b1);
            end
        end
        chk("full len256", prog_len, 9'd256);
        chk("full hold", cpu_hold, 1'b0);
        chk("full ready", load_ready, 1'b0);
        drive(1, 0, 0, 8'h00, 0, 1, 8'hFF);
        tick();
        chk("full pc255", instruction, 8'hFF);
        chk("full vld255", instr_valid, 1'b1);
        drive(1, 0, 0, 8'h00, 0, 1, 8'h80);
        tick();
        chk("full pc128", instruction, 8'h80);
        chk("full vld128", instr_valid, 1'b1);

        // Short program over the stale full-depth image, then an out-of-range fetch.
        drive(1, 1, 0, 8'h00, 0, 0, 8'h00);
        tick();
        drive(1, 0, 1, 8'h41, 0, 0, 8'h00); tick();
        drive(1, 0, 1, 8'h82, 0, 0, 8'h00); tick();
        drive(1, 0, 1, 8'hC3, 1, 0, 8'h00); tick();
        chk("short len", prog_len, 9'd3);
        drive(1, 0, 0, 8'h00, 0, 1, 8'h05);
        tick();
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("oob instruction", instruction, 8'h00);
        chk("oob vld", instr_valid, 1'b1);
        chk("oob fault", fault, 1'b1);
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        chk("fault sticky idle", fault, 1'b1);
        drive(1, 0, 0, 8'h00, 0, 1, 8'h01);
        tick();
        chk("inrange after fault", instruction, 8'h82);
        chk("fault sticky fetch", fault, 1'b1);
        drive(1, 1, 0, 8'h00, 0, 0, 8'h00);
        tick();
        chk("fault cleared", fault, 1'b0);
        chk("restart ready", load_ready, 1'b1);
`else
        chk("raw stale instruction", instruction, 8'h05);
        chk("raw vld", instr_valid, 1'b1);
        chk("raw fault", fault, 1'b0);
        drive(1, 0, 0, 8'h00, 0, 1, 8'h02);
        tick();
        chk("short pc2", instruction, 8'hC3);
`endif
        drive(1, 0, 0, 8'h00, 0, 0, 8'h00);
        tick();
        chk("idle vld", instr_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
